bram_bist_master: RTL and testbench
===================================

// Module: bram_bist_master
// PURPOSE
//  Initiator for the single-port 32x32 BRAM slave interface (cs/rd/wr, word address [6:2], 1-cycle read latency).
//  On a start pulse, writes an address-derived pattern to every word, reads all words back and compares each one.
//  Reports pass/fail and the first failing word address.
//  Used for power-on memory test and board bring-up; muxed onto the BRAM port ahead of the CPU.
// PARAMETERS
//  DEPTH    32             words tested, from address 0 to DEPTH-1; legal range 1..32
//  PATTERN  32'hA5A5_0000  base data word; pattern(a) = PATTERN ^ {27'd0, a[4:0]}
// PORTS
//  clk        in   1   single clock; all logic on posedge
//  resetn     in   1   synchronous, active-low reset
//  start      in   1   1-cycle pulse; sampled only in IDLE
//  busy       out  1   high from the cycle after start until DONE is left
//  done       out  1   1-cycle pulse at end of test
//  pass       out  1   1 = no mismatch in last run; valid from done, held until next start
//  fail_addr  out  5   first mismatching word address; 0 if pass
//  mem_addr   out  5   word address to BRAM (drives slave mem_addr[6:2])
//  cs         out  1   BRAM chip select
//  rd         out  1   BRAM read strobe
//  wr         out  1   BRAM write strobe
//  mem_wdata  out  32  write data
//  mem_rdata  in   32  BRAM read data; valid the cycle after a cs&rd edge
// BEHAVIOUR
//  - All outputs are registered.
//  - On reset, every output is 0 and the FSM is in IDLE.
//  - Reset mid-test aborts: cs/rd/wr are low after that edge; pass/fail_addr are cleared; no done pulse.
//  - FSM states: IDLE -> WRITE -> READ -> DRAIN -> DONE -> IDLE.
//  - IDLE: cs=rd=wr=0. start=1 -> WRITE; addr=0; pass<=1; fail_addr<=0; busy<=1.
//  - WRITE: cs=wr=1, rd=0, mem_wdata=pattern(addr).
//    - DEPTH cycles, addr incrementing by 1.
//    - At addr==DEPTH-1 -> READ with addr=0.
//  - READ: cs=rd=1, wr=0 for DEPTH cycles.
//    - Each cycle compares mem_rdata with pattern(addr-1), from a 1-stage expected-address pipeline.
//    - No compare in the first READ cycle.
//    - At addr==DEPTH-1 -> DRAIN.
//  - DRAIN: cs=rd=0; compare the last word.
//  - DONE: done=1 for 1 cycle, busy=0 on exit.
//  - Mismatch: pass<=0. fail_addr is captured only on the first mismatch; later mismatches do not overwrite it.
//  - rd and wr are never high together. cs is high iff rd or wr is high.
//  - The address counter never wraps past DEPTH-1 (width 5; DEPTH=32 ends at 31, no overflow use).
//  - start while busy is ignored. start in DONE is ignored (accepted again from IDLE).
//  - Latency, start edge to done pulse: 2*DEPTH+2 cycles (66 at default).
// CONFIGURATION
//  BIST_INV_PASS_EN defined:
//    - After the first DRAIN, a second WRITE/READ/DRAIN pass runs with ~pattern(a); then DONE.
//    - Latency becomes 4*DEPTH+3 cycles (131 at default). Mismatch rules span both passes.
//    - A 1-bit pass-index register selects the data polarity.
//  Not defined:
//    - Single pass only; no pass-index register.
// TESTING
//  1. Ideal BRAM model, start pulse
//     -> 32 writes (addr 0..31, wdata[0]=A5A5_0000, wdata[31]=A5A5_001F), then 32 reads;
//        done at cycle 66; pass=1; fail_addr=0.
//  2. Model forces rdata[0]=0 on reads of addr 5 and addr 9
//     -> pass=0; fail_addr=5 (not 9).
//  3. start re-pulsed at cycles 10 and 40 of a run
//     -> ignored; exactly one done pulse at cycle 66; cs never glitches.
//  4. resetn=0 for 1 cycle at cycle 20
//     -> next cycle cs=rd=wr=busy=pass=0, no done pulse;
//        a fresh start then completes normally with pass=1.
//  5. BIST_INV_PASS_EN, model bit 31 stuck-at-1 at addr 0
//     -> pass-1 reads return 5A5A_FFFF|8000_0000; pass=0; fail_addr=0; done at cycle 131.
//     -> Same fault without the macro: pass=1, done at cycle 66.
//  6. DEPTH=4 build
//     -> addr sequence 0..3 write then 0..3 read; done at cycle 10; BRAM words 4..31 untouched.

Source files
------------

// File: rtl/bram_bist_master_if.sv
// BRAM slave port bundle: word address, chip select, read/write strobes and data.
// The master drives the strobes and the address. The slave returns read data one cycle later.
interface bram_bist_master_if;
  logic [4:0]  mem_addr;
  logic        cs;
  logic        rd;
  logic        wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (output mem_addr, cs, rd, wr, mem_wdata, input mem_rdata);
  modport slave  (input mem_addr, cs, rd, wr, mem_wdata, output mem_rdata);
endinterface

// File: rtl/bram_bist_master.sv
// BRAM march-style self test: writes pattern(a) to every word, reads it back and records the first mismatch.
// Optional macro BIST_INV_PASS_EN adds a second pass that uses the inverted pattern.
module bram_bist_master #(
  parameter int unsigned DEPTH   = 32,
  parameter logic [31:0] PATTERN = 32'hA5A5_0000
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [4:0]           fail_addr,
  bram_bist_master_if.master   bus
);

  localparam int unsigned AW = 5;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, FIN} state_t;

  state_t        state;
  logic [AW-1:0] addr_q;
  logic          cs_q, rd_q, wr_q;
  logic [31:0]   wdata_q;
  logic          rd_pend;
  logic [AW-1:0] exp_addr;
  logic          pol;

  function automatic logic [31:0] pat(input logic [AW-1:0] a, input logic inv);
    return PATTERN ^ {27'd0, a} ^ {32{inv}};
  endfunction

`ifdef BIST_INV_PASS_EN
  logic pass_idx;
  assign pol = pass_idx;
`else
  assign pol = 1'b0;
`endif

  assign bus.mem_addr  = addr_q;
  assign bus.cs        = cs_q;
  assign bus.rd        = rd_q;
  assign bus.wr        = wr_q;
  assign bus.mem_wdata = wdata_q;

  // Read data lags the issued address by one cycle, so each compare uses the delayed address.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      addr_q    <= '0;
      cs_q      <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      rd_pend   <= 1'b0;
      exp_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_addr <= '0;
`ifdef BIST_INV_PASS_EN
      pass_idx  <= 1'b0;
`endif
    end else begin
      done     <= 1'b0;
      rd_pend  <= (state == READ);
      exp_addr <= addr_q;

      if (rd_pend && (bus.mem_rdata != pat(exp_addr, pol))) begin
        pass <= 1'b0;
        if (pass) fail_addr <= exp_addr;
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= WRITE;
            addr_q    <= '0;
            cs_q      <= 1'b1;
            wr_q      <= 1'b1;
            wdata_q   <= pat('0, 1'b0);
            pass      <= 1'b1;
            fail_addr <= '0;
            busy      <= 1'b1;
`ifdef BIST_INV_PASS_EN
            pass_idx  <= 1'b0;
`endif
          end
        end
        WRITE: begin
          if (addr_q == LAST) begin
            state   <= READ;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b1;
            wdata_q <= '0;
          end else begin
            addr_q  <= addr_q + AW'(1);
            wdata_q <= pat(addr_q + AW'(1), pol);
          end
        end
        READ: begin
          if (addr_q == LAST) begin
            state  <= DRAIN;
            addr_q <= '0;
            cs_q   <= 1'b0;
            rd_q   <= 1'b0;
          end else begin
            addr_q <= addr_q + AW'(1);
          end
        end
        DRAIN: begin
`ifdef BIST_INV_PASS_EN
          if (!pass_idx) begin
            pass_idx <= 1'b1;
            state    <= WRITE;
            addr_q   <= '0;
            cs_q     <= 1'b1;
            wr_q     <= 1'b1;
            wdata_q  <= pat('0, 1'b1);
          end else begin
            state <= FIN;
            done  <= 1'b1;
          end
`else
          state <= FIN;
          done  <= 1'b1;
`endif
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_bist_master.sv
// Self-checking bench for bram_bist_master: a BRAM model with injectable stuck-at faults and a pattern-level reference.
module tb_bram_bist_master;
  localparam int unsigned D   = 32;
`ifdef BIST_INV_PASS_EN
  localparam int unsigned NP  = 2;
`else
  localparam int unsigned NP  = 1;
`endif
  localparam int unsigned LAT = (NP == 2) ? 4*D + 3 : 2*D + 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic start = 1'b0;
  logic busy, done, pass;
  logic [4:0] fail_addr;

  bram_bist_master_if bus();

  bram_bist_master #(.DEPTH(D)) dut (
    .clk(clk), .resetn(resetn), .start(start), .busy(busy), .done(done),
    .pass(pass), .fail_addr(fail_addr), .bus(bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [32];
  logic        fen  [32];
  int          fbit [32];
  logic        fval [32];

  function automatic logic [31:0] apply_fault(input logic [31:0] w, input int a);
    logic [31:0] r;
    r = w;
    if (fen[a]) r[fbit[a]] = fval[a];
    return r;
  endfunction

  function automatic logic [31:0] ref_pattern(input int a, input int p);
    return 32'hA5A5_0000 ^ 32'(a) ^ ((p != 0) ? 32'hFFFF_FFFF : 32'h0);
  endfunction

  // BRAM model: one-cycle read latency, faults applied on the read path.
  always @(posedge clk) begin
    if (bus.cs && bus.wr) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.cs && bus.rd) bus.mem_rdata <= apply_fault(mem[bus.mem_addr], int'(bus.mem_addr));
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_faults();
    for (int a = 0; a < 32; a++) begin
      fen[a] = 1'b0; fbit[a] = 0; fval[a] = 1'b0;
    end
  endtask

  // Expected verdict: walk every address of every pass in order and stop at the first faulty read.
  task automatic ref_result(output logic exp_pass, output int exp_fa);
    logic [31:0] w;
    exp_pass = 1'b1;
    exp_fa = 0;
    for (int p = 0; p < int'(NP); p++)
      for (int a = 0; a < int'(D); a++) begin
        w = ref_pattern(a, p);
        if (exp_pass && (apply_fault(w, a) != w)) begin
          exp_pass = 1'b0;
          exp_fa = a;
        end
      end
  endtask

  int done_cyc, ndone, nwr, nrd, proto, seq_err, cs_rise, busy_err;
  logic [31:0] w_first, w_last;

  task automatic run(input int ra, input int rb, input int rst_at);
    logic prev_cs;
    int ea;
    @(negedge clk);
    start = 1'b1;
    done_cyc = -1; ndone = 0; nwr = 0; nrd = 0; proto = 0; seq_err = 0;
    cs_rise = 0; busy_err = 0; prev_cs = 1'b0; w_first = '0; w_last = '0;
    for (int n = 1; n <= int'(LAT) + 8; n++) begin
      @(posedge clk); #1;
      start = (n == ra || n == rb);
      if (n == rst_at) resetn = 1'b0;
      if (rst_at > 0 && n == rst_at + 1) begin
        check("rst_cs",   32'(bus.cs), 32'd0);
        check("rst_rd",   32'(bus.rd), 32'd0);
        check("rst_wr",   32'(bus.wr), 32'd0);
        check("rst_busy", 32'(busy),   32'd0);
        check("rst_pass", 32'(pass),   32'd0);
        resetn = 1'b1;
      end
      if (bus.rd && bus.wr) proto++;
      if (bus.cs !== (bus.rd | bus.wr)) proto++;
      if (bus.cs && !prev_cs) cs_rise++;
      prev_cs = bus.cs;
      if (rst_at == 0 && busy !== (n <= int'(LAT))) busy_err++;
      if (done) begin
        ndone++;
        if (ndone == 1) done_cyc = n;
      end
      if (bus.cs && bus.wr) begin
        ea = nwr % int'(D);
        if (int'(bus.mem_addr) != ea || bus.mem_wdata !== ref_pattern(ea, nwr / int'(D))) seq_err++;
        if (nwr == 0) w_first = bus.mem_wdata;
        if (nwr == int'(D) - 1) w_last = bus.mem_wdata;
        nwr++;
      end
      if (bus.cs && bus.rd) begin
        if (int'(bus.mem_addr) != nrd % int'(D)) seq_err++;
        nrd++;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_verdict(input string tag);
    logic ep;
    int efa;
    ref_result(ep, efa);
    check({tag, "_pass"}, 32'(pass), 32'(ep));
    check({tag, "_fail_addr"}, 32'(fail_addr), 32'(efa));
    check({tag, "_done_cyc"}, 32'(done_cyc), 32'(LAT));
    check({tag, "_ndone"}, 32'(ndone), 32'd1);
  endtask

  initial begin
    int nf, a;
    clear_faults();
    for (int i = 0; i < 32; i++) mem[i] = $urandom;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_pass", 32'(pass), 32'd0);
    check("reset_fail_addr", 32'(fail_addr), 32'd0);
    check("reset_strobes", {29'd0, bus.cs, bus.rd, bus.wr}, 32'd0);
    check("reset_addr", 32'(bus.mem_addr), 32'd0);
    check("reset_wdata", bus.mem_wdata, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Ideal BRAM
    run(0, 0, 0);
    check_verdict("ideal");
    check("ideal_nwr", 32'(nwr), 32'(NP * D));
    check("ideal_nrd", 32'(nrd), 32'(NP * D));
    check("ideal_wdata0", w_first, 32'hA5A5_0000);
    check("ideal_wdata31", w_last, 32'hA5A5_001F);
    check("ideal_seq", 32'(seq_err), 32'd0);
    check("ideal_proto", 32'(proto), 32'd0);
    check("ideal_busy", 32'(busy_err), 32'd0);

    // bit 0 stuck low at addresses 5 and 9: first failure wins
    clear_faults();
    fen[5] = 1'b1; fbit[5] = 0; fval[5] = 1'b0;
    fen[9] = 1'b1; fbit[9] = 0; fval[9] = 1'b0;
    run(0, 0, 0);
    check_verdict("two_faults");
    check("two_faults_addr5", 32'(fail_addr), 32'd5);

    // start re-pulsed while busy
    clear_faults();
    run(10, 40, 0);
    check_verdict("repulse");
    check("repulse_cs_rise", 32'(cs_rise), 32'(NP));
    check("repulse_proto", 32'(proto), 32'd0);

    // reset mid-test, then a clean run
    run(0, 0, 20);
    check("abort_ndone", 32'(ndone), 32'd0);
    check("abort_pass_held", 32'(pass), 32'd0);
    run(0, 0, 0);
    check_verdict("after_abort");

    // bit 31 stuck-at-1 at address 0 only shows up under the inverted pattern
    clear_faults();
    fen[0] = 1'b1; fbit[0] = 31; fval[0] = 1'b1;
    run(0, 0, 0);
    check_verdict("stuck31");

    // random fault sets
    for (int it = 0; it < 6; it++) begin
      clear_faults();
      nf = int'($urandom_range(1, 3));
      for (int k = 0; k < nf; k++) begin
        a = int'($urandom_range(0, D - 1));
        fen[a] = 1'b1;
        fbit[a] = int'($urandom_range(0, 31));
        fval[a] = 1'($urandom_range(0, 1));
      end
      repeat ($urandom_range(0, 4)) @(negedge clk);
      run(0, 0, 0);
      check_verdict($sformatf("rand%0d", it));
      check($sformatf("rand%0d_seq", it), 32'(seq_err), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
